// File: rtl/axilite_arbiter_2to1.sv
// axilite_arbiter_2to1
//   Shares one AXI-Lite slave between two AXI-Lite masters. Round-robin
//   arbitration with exactly one transaction (write or read) in flight; the
//   grant is held from address acceptance to response completion.
//
// Ports
//   aclk, aresetn     rising-edge clock, asynchronous active-low reset
//   s0_* / s1_*       slave-side AXI-Lite channels from requester 0 / 1
//                     (AW, W, B, AR, R; no prot)
//   m_*               master-side AXI-Lite channels to the shared slave
//   grant[1:0]        one-hot owner of the shared slave, 0 when idle
//   busy              transaction in flight (FSM not idle)
module axilite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // requester 0
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [ADDR_WIDTH-1:0] s0_awaddr,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic [STRB_W-1:0]     s0_wstrb,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    output logic [1:0]            s0_bresp,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    // requester 1
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [ADDR_WIDTH-1:0] s1_awaddr,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    input  logic [STRB_W-1:0]     s1_wstrb,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [1:0]            s1_bresp,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    // shared slave
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_W-1:0]     m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    // status
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    logic [2:0] state;
    logic [1:0] grant_q;
    logic       rr_last;   // index of the requester served last
    logic       aw_done;
    logic       w_done;

    // requester channels packed by index so the mux is a plain select
    logic [1:0]                 awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
    logic [1:0][ADDR_WIDTH-1:0] awaddr_v, araddr_v;
    logic [1:0][DATA_WIDTH-1:0] wdata_v;
    logic [1:0][STRB_W-1:0]     wstrb_v;
    logic [1:0]                 awready_v, wready_v, bvalid_v, arready_v, rvalid_v;

    assign awvalid_v = {s1_awvalid, s0_awvalid};
    assign wvalid_v  = {s1_wvalid,  s0_wvalid};
    assign bready_v  = {s1_bready,  s0_bready};
    assign arvalid_v = {s1_arvalid, s0_arvalid};
    assign rready_v  = {s1_rready,  s0_rready};
    assign awaddr_v  = {s1_awaddr,  s0_awaddr};
    assign araddr_v  = {s1_araddr,  s0_araddr};
    assign wdata_v   = {s1_wdata,   s0_wdata};
    assign wstrb_v   = {s1_wstrb,   s0_wstrb};

    logic [1:0] wreq_v, req_v;
    logic       win;
    logic       sel;
    logic       in_write, in_wresp, in_read, in_rdata;
    logic       aw_fire, w_fire, b_fire, ar_fire, r_fire;

    assign wreq_v = awvalid_v | wvalid_v;
    assign req_v  = wreq_v | arvalid_v;

    // Contention goes to whoever was not served last; a lone requester wins outright.
    always_comb begin
        win = req_v[1];
        if (req_v == 2'b11)
            win = ~rr_last;
    end

    assign sel      = grant_q[1];
    assign in_write = (state == WRITE);
    assign in_wresp = (state == WRESP);
    assign in_read  = (state == READ);
    assign in_rdata = (state == RDATA);

    // Downstream: granted requester passes through; a finished write channel is masked.
    assign m_awvalid = in_write & ~aw_done & awvalid_v[sel];
    assign m_awaddr  = awaddr_v[sel];
    assign m_wvalid  = in_write & ~w_done & wvalid_v[sel];
    assign m_wdata   = wdata_v[sel];
    assign m_wstrb   = wstrb_v[sel];
    assign m_bready  = in_wresp & bready_v[sel];
    assign m_arvalid = in_read & arvalid_v[sel];
    assign m_araddr  = araddr_v[sel];
    assign m_rready  = in_rdata & rready_v[sel];

    // Upstream: readies and response valids only reach the owner.
    for (genvar i = 0; i < 2; i++) begin : g_req
        assign awready_v[i] = grant_q[i] & in_write & ~aw_done & m_awready;
        assign wready_v[i]  = grant_q[i] & in_write & ~w_done  & m_wready;
        assign bvalid_v[i]  = grant_q[i] & in_wresp & m_bvalid;
        assign arready_v[i] = grant_q[i] & in_read  & m_arready;
        assign rvalid_v[i]  = grant_q[i] & in_rdata & m_rvalid;
    end

    assign {s1_awready, s0_awready} = awready_v;
    assign {s1_wready,  s0_wready}  = wready_v;
    assign {s1_bvalid,  s0_bvalid}  = bvalid_v;
    assign {s1_arready, s0_arready} = arready_v;
    assign {s1_rvalid,  s0_rvalid}  = rvalid_v;

    // Response payloads are broadcast; valid alone qualifies them.
    assign s0_bresp = m_bresp;
    assign s1_bresp = m_bresp;
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;

    assign aw_fire = m_awvalid & m_awready;
    assign w_fire  = m_wvalid  & m_wready;
    assign b_fire  = m_bvalid  & m_bready;
    assign ar_fire = m_arvalid & m_arready;
    assign r_fire  = m_rvalid  & m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant_q <= 2'b00;
            rr_last <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_v) begin
                        grant_q <= win ? 2'b10 : 2'b01;
                        state   <= wreq_v[win] ? WRITE : READ;
                    end
                end
                WRITE: begin
                    // AW and W complete independently, in any order or together.
                    if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                        state   <= WRESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_fire) aw_done <= 1'b1;
                        if (w_fire)  w_done  <= 1'b1;
                    end
                end
                WRESP: begin
                    if (b_fire) begin
                        rr_last <= sel;
                        grant_q <= 2'b00;
                        state   <= IDLE;
                    end
                end
                READ: begin
                    if (ar_fire) state <= RDATA;
                end
                RDATA: begin
                    if (r_fire) begin
                        rr_last <= sel;
                        grant_q <= 2'b00;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_axilite_arbiter_2to1.sv
// tb_axilite_arbiter_2to1
//   Two master driver threads, a memory-backed slave model on the shared port,
//   and a negedge monitor that pops expected responses per requester and checks
//   grant ownership against a round-robin model.
module tb_axilite_arbiter_2to1;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // requester-side (index 0/1 = s0/s1)
    logic        awvalid [2], wvalid [2], bready [2], arvalid [2], rready [2];
    logic [9:0]  awaddr  [2], araddr [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2];
    logic [1:0]  bresp   [2], rresp  [2];
    logic [31:0] rdata   [2];

    // shared-slave side
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [9:0]  m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [1:0]  grant;
    logic        busy;

    axilite_arbiter_2to1 #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_awvalid(awvalid[0]), .s0_awready(awready[0]), .s0_awaddr(awaddr[0]),
        .s0_wvalid(wvalid[0]), .s0_wready(wready[0]), .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]),
        .s0_bvalid(bvalid[0]), .s0_bready(bready[0]), .s0_bresp(bresp[0]),
        .s0_arvalid(arvalid[0]), .s0_arready(arready[0]), .s0_araddr(araddr[0]),
        .s0_rvalid(rvalid[0]), .s0_rready(rready[0]), .s0_rdata(rdata[0]), .s0_rresp(rresp[0]),
        .s1_awvalid(awvalid[1]), .s1_awready(awready[1]), .s1_awaddr(awaddr[1]),
        .s1_wvalid(wvalid[1]), .s1_wready(wready[1]), .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]),
        .s1_bvalid(bvalid[1]), .s1_bready(bready[1]), .s1_bresp(bresp[1]),
        .s1_arvalid(arvalid[1]), .s1_arready(arready[1]), .s1_araddr(araddr[1]),
        .s1_rvalid(rvalid[1]), .s1_rready(rready[1]), .s1_rdata(rdata[1]), .s1_rresp(rresp[1]),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .grant(grant), .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    logic        slv_rand = 1'b0;
    logic        stall_r  = 1'b0;
    logic        got_aw, got_w, got_ar;
    logic [9:0]  waddr_q, raddr_q;
    logic [31:0] wdat_q;
    logic [31:0] smem [256];

    wire        aw_hs   = m_awvalid & m_awready;
    wire        w_hs    = m_wvalid & m_wready;
    wire        ar_hs   = m_arvalid & m_arready;
    wire        have_aw = got_aw | aw_hs;
    wire        have_w  = got_w | w_hs;
    wire        have_ar = got_ar | ar_hs;
    wire [9:0]  wa      = aw_hs ? m_awaddr : waddr_q;
    wire [31:0] wd      = w_hs ? m_wdata : wdat_q;

    assign m_bresp = 2'b00;
    assign m_rresp = 2'b00;

    function automatic logic rbit();
        return slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_awready <= 1'b0; m_wready <= 1'b0; m_arready <= 1'b0;
            m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0;
            got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0;
            waddr_q <= '0; wdat_q <= '0; raddr_q <= '0;
            for (int i = 0; i < 256; i++) smem[i] <= '0;
        end else begin
            if (aw_hs) begin got_aw <= 1'b1; waddr_q <= m_awaddr; end
            if (w_hs)  begin got_w  <= 1'b1; wdat_q  <= m_wdata;  end
            m_awready <= !have_aw && !m_bvalid && rbit();
            m_wready  <= !have_w  && !m_bvalid && rbit();
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            else if (!m_bvalid && have_aw && have_w && rbit()) begin
                smem[wa[9:2]] <= wd;
                m_bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (ar_hs) begin got_ar <= 1'b1; raddr_q <= m_araddr; end
            m_arready <= !have_ar && !m_rvalid && rbit();
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            else if (!m_rvalid && got_ar && !stall_r && rbit()) begin
                m_rdata <= smem[raddr_q[9:2]];
                m_rvalid <= 1'b1; got_ar <= 1'b0;
            end
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct { bit rd; logic [31:0] data; } exp_t;
    exp_t        q0[$], q1[$];
    logic [31:0] ref_mem [256];
    logic [1:0]  gseq[$];
    int          b_cnt [2], r_cyc [2], b_cyc [2];
    int          aw_cyc = 0, w_cyc = 0, cyc = 0;

    task automatic push_exp(input int m, input bit rd, input logic [31:0] d);
        exp_t e;
        e.rd = rd; e.data = d;
        if (m == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        q0.delete(); q1.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit         prev_idle = 0, exp_idle = 0, last_w = 1;
        logic [1:0] prev_req = 0, prev_grant = 0, exp_g;
        exp_t       e;
        forever begin
            @(negedge aclk);
            cyc++;
            if (!aresetn) begin
                prev_idle = 0; exp_idle = 0; last_w = 1; prev_grant = 0;
                continue;
            end
            check("grant_legal", {31'b0, grant == 2'b11}, 0);
            check("busy_vs_grant", {31'b0, busy}, {31'b0, grant != 2'b00});
            if (prev_idle) begin
                exp_g = (prev_req == 2'b11) ? (last_w ? 2'b01 : 2'b10) : prev_req;
                check("rr_grant", {30'b0, grant}, {30'b0, exp_g});
            end
            if (exp_idle) check("idle_gap", {30'b0, grant}, 0);
            exp_idle = 0;
            if (grant != 0) last_w = grant[1];
            if (grant != 0 && prev_grant == 0) gseq.push_back(grant);
            prev_grant = grant;
            prev_idle = (grant == 0);
            prev_req = {awvalid[1] | wvalid[1] | arvalid[1], awvalid[0] | wvalid[0] | arvalid[0]};
            check("aw_mask", {31'b0, m_awvalid & got_aw}, 0);
            check("w_mask",  {31'b0, m_wvalid & got_w}, 0);
            check("ar_mask", {31'b0, m_arvalid & got_ar}, 0);
            if (aw_hs) aw_cyc = cyc;
            if (w_hs)  w_cyc  = cyc;
            for (int m = 0; m < 2; m++) begin
                check("bvalid_owner", {31'b0, bvalid[m] & ~grant[m]}, 0);
                check("rvalid_owner", {31'b0, rvalid[m] & ~grant[m]}, 0);
                if ((bvalid[m] && bready[m]) || (rvalid[m] && rready[m])) begin
                    exp_idle = 1;
                    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        check("unexpected_resp", 1, 0);
                        continue;
                    end
                    e = (m == 0) ? q0.pop_front() : q1.pop_front();
                    if (bvalid[m] && bready[m]) begin
                        b_cnt[m]++; b_cyc[m] = cyc;
                        check("resp_kind_b", {31'b0, e.rd}, 0);
                        check("bresp", {30'b0, bresp[m]}, 0);
                    end else begin
                        r_cyc[m] = cyc;
                        check("resp_kind_r", {31'b0, e.rd}, 1);
                        check("rdata", rdata[m], e.data);
                    end
                end
            end
        end
    end

    // ---------------- master drivers (start and end at posedge+1) ----------------
    task automatic mwrite(input int m, input logic [9:0] a, input logic [31:0] d,
                          input int wlead, input bit push);
        bit aw_ok = 0, w_ok = 0, b_ok = 0;
        int t = 0;
        if (push) begin push_exp(m, 0, 0); ref_mem[a[9:2]] = d; end
        awaddr[m] = a; wdata[m] = d;
        while (!(aw_ok && w_ok)) begin
            awvalid[m] = !aw_ok && (t >= (wlead > 0 ? wlead : 0));
            wvalid[m]  = !w_ok  && (t >= (wlead < 0 ? -wlead : 0));
            @(negedge aclk);
            if (awvalid[m] && awready[m]) aw_ok = 1;
            if (wvalid[m] && wready[m])   w_ok = 1;
            @(posedge aclk); #1;
            t++;
        end
        awvalid[m] = 0; wvalid[m] = 0;
        while (!b_ok) begin
            bready[m] = 1'($urandom_range(0, 1));
            @(negedge aclk);
            b_ok = bvalid[m] && bready[m];
            @(posedge aclk); #1;
        end
        bready[m] = 0;
    endtask

    task automatic mread(input int m, input logic [9:0] a, input bit push);
        bit ar_ok = 0, r_ok = 0;
        if (push) push_exp(m, 1, ref_mem[a[9:2]]);
        araddr[m] = a; arvalid[m] = 1;
        while (!ar_ok) begin
            @(negedge aclk);
            ar_ok = arvalid[m] && arready[m];
            @(posedge aclk); #1;
        end
        arvalid[m] = 0;
        while (!r_ok) begin
            rready[m] = 1'($urandom_range(0, 1));
            @(negedge aclk);
            r_ok = rvalid[m] && rready[m];
            @(posedge aclk); #1;
        end
        rready[m] = 0;
    endtask

    task automatic do_reset();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk); #1;
        aresetn = 1;
        clear_ref();
        @(posedge aclk); #1;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = 10'((64 * (m + 1) + $urandom_range(0, 15)) * 4);
            if ($urandom_range(0, 1) == 1) mwrite(m, a, $urandom, $urandom_range(0, 4) - 2, 1);
            else mread(m, a, 1);
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (40000) @(posedge aclk);
        fails++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int bc0, bc1, bc1_old;
        for (int m = 0; m < 2; m++) begin
            awvalid[m] = 0; wvalid[m] = 0; bready[m] = 0; arvalid[m] = 0; rready[m] = 0;
            awaddr[m] = 0; araddr[m] = 0; wdata[m] = 0; wstrb[m] = 4'hF;
            b_cnt[m] = 0; r_cyc[m] = 0; b_cyc[m] = 0;
        end
        aresetn = 0;
        #12;
        check("rst_grant", {30'b0, grant}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_m_valids", {29'b0, m_awvalid, m_wvalid, m_arvalid}, 0);
        check("rst_s_outs", {28'b0, awready[0], bvalid[1], rvalid[0], arready[1]}, 0);
        do_reset();

        // 1: lone write from s0
        bc1 = b_cnt[1];
        mwrite(0, 10'h004, 32'hDEADBEEF, 0, 1);
        check("t1_mem", smem[1], 32'hDEADBEEF);
        check("t1_s1_no_b", b_cnt[1], bc1);
        check("t1_s0_b", b_cnt[0], 1);

        // 2: simultaneous reads right after reset -> s0 first
        do_reset();
        fork
            mread(0, 10'h008, 1);
            mread(1, 10'h00C, 1);
        join
        check("t2_order", {31'b0, r_cyc[0] < r_cyc[1]}, 1);

        // 3: 4 writes from each master, grants alternate, read back
        gseq.delete();
        fork
            for (int i = 0; i < 4; i++) mwrite(0, 10'((16 + i) * 4), 32'hA000_0000 + i, 0, 1);
            for (int i = 0; i < 4; i++) mwrite(1, 10'((32 + i) * 4), 32'hB000_0000 + i, 0, 1);
        join
        check("t3_ngrants", gseq.size(), 8);
        for (int i = 1; i < gseq.size(); i++) check("t3_alternate", {31'b0, gseq[i] != gseq[i-1]}, 1);
        for (int i = 0; i < 4; i++) begin
            mread(0, 10'((16 + i) * 4), 1);
            mread(1, 10'((32 + i) * 4), 1);
        end

        // 4: s1 presents W three cycles before AW
        bc0 = b_cnt[0]; bc1_old = b_cnt[1];
        mwrite(1, 10'h040, 32'h1234_5678, 3, 1);
        check("t4_w_before_aw", {31'b0, w_cyc < aw_cyc}, 1);
        check("t4_b_after_aw", {31'b0, b_cyc[1] > aw_cyc}, 1);
        check("t4_one_b_s1", b_cnt[1] - bc1_old, 1);
        check("t4_no_b_s0", b_cnt[0] - bc0, 0);

        // 5: s0 write and same-address read raised together
        push_exp(0, 0, 0);
        ref_mem[10'h050 >> 2] = 32'hCAFE_F00D;
        push_exp(0, 1, 32'hCAFE_F00D);
        fork
            mwrite(0, 10'h050, 32'hCAFE_F00D, 0, 0);
            mread(0, 10'h050, 0);
        join
        check("t5_drained", q0.size(), 0);

        // 6: reset during RDATA
        stall_r = 1;
        araddr[0] = 10'h008; arvalid[0] = 1; rready[0] = 1;
        for (int i = 0; i < 20 && !(m_arvalid && m_arready); i++) begin
            @(negedge aclk);
            if (m_arvalid && m_arready) break;
        end
        @(posedge aclk); #1;
        arvalid[0] = 0;
        check("t6_busy_before", {31'b0, busy}, 1);
        #2 aresetn = 0;
        #1;
        check("t6_grant", {30'b0, grant}, 0);
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_valids", {28'b0, m_awvalid, m_wvalid, m_arvalid, rvalid[0]}, 0);
        rready[0] = 0; stall_r = 0;
        @(negedge aclk); #1;
        aresetn = 1;
        clear_ref();
        @(posedge aclk); #1;
        mwrite(1, 10'h0F0, 32'h0BAD_CAFE, -1, 1);
        mread(0, 10'h0F0, 1);

        // randomized concurrent traffic with a stalling slave
        slv_rand = 1;
        fork
            rand_master(0, 30);
            rand_master(1, 30);
        join
        repeat (3) @(posedge aclk);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
